// File: rtl/program_counter_if.sv
// program_counter_if: load/increment controls and bus value into the PC, current PC value out to AR.
interface program_counter_if #(
    parameter int reg_width = 12
);
    logic                 write_en;
    logic                 increment;
    logic [reg_width-1:0] bus_data_in;
    logic [reg_width-1:0] AR_data_out;
    modport master (output write_en, increment, bus_data_in, input AR_data_out);
    modport slave  (input write_en, increment, bus_data_in, output AR_data_out);
endinterface

// File: rtl/program_counter.sv
// program_counter: PC register that loads a bus value or steps by one; reset returns it to the reset vector.
module program_counter #(
    parameter int                   reg_width        = 12,
    parameter logic [reg_width-1:0] current_PC_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    program_counter_if.slave   pc_if
);
    logic [reg_width-1:0] pc_q, pc_d;
    // A load wins over an increment issued in the same cycle.
    always_comb begin
        pc_d = pc_if.write_en  ? pc_if.bus_data_in :
               pc_if.increment ? pc_q + 1'b1 : pc_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) pc_q <= current_PC_value;
        else        pc_q <= pc_d;
    end
    assign pc_if.AR_data_out = pc_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: drives two PCs (reset vectors 0 and 0x100) with directed and random stimulus against a reference model.
module tb_program_counter;
    logic clk, reset;
    int   checks = 0, errors = 0;
    int   exp_a, exp_b;
    bit   valid = 0;

    program_counter_if #(.reg_width(12)) if_a ();
    program_counter_if #(.reg_width(12)) if_b ();

    program_counter #(.reg_width(12), .current_PC_value(12'h000)) dut_a (.clk(clk), .reset(reset), .pc_if(if_a.slave));
    program_counter #(.reg_width(12), .current_PC_value(12'h100)) dut_b (.clk(clk), .reset(reset), .pc_if(if_b.slave));

    assign if_b.write_en    = if_a.write_en;
    assign if_b.increment   = if_a.increment;
    assign if_b.bus_data_in = if_a.bus_data_in;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [11:0] act, input int exp);
        checks++;
        if (act !== exp[11:0]) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp[11:0]);
        end
    endtask

    // Reference: next PC from the priority rules, modulo 4096.
    always @(posedge clk) begin
        if (!reset) begin
            exp_a = 'h000;
            exp_b = 'h100;
            valid = 1;
        end else if (if_a.write_en) begin
            exp_a = int'(if_a.bus_data_in);
            exp_b = int'(if_a.bus_data_in);
        end else if (if_a.increment) begin
            exp_a = (exp_a + 1) % 4096;
            exp_b = (exp_b + 1) % 4096;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("model_a", if_a.AR_data_out, exp_a);
            chk("model_b", if_b.AR_data_out, exp_b);
        end
    end

    task automatic step(input logic r, input logic we, input logic inc, input logic [11:0] bus);
        reset = r;
        if_a.write_en = we;
        if_a.increment = inc;
        if_a.bus_data_in = bus;
        @(negedge clk);
    endtask

    initial begin
        step(1'b0, 1'b1, 1'b0, 12'hABC);
        chk("reset_a", if_a.AR_data_out, 'h000);
        chk("reset_b", if_b.AR_data_out, 'h100);
        step(1'b1, 1'b1, 1'b0, 12'hE08);
        chk("load", if_a.AR_data_out, 'hE08);
        step(1'b1, 1'b0, 1'b1, 12'h555);
        chk("inc1", if_a.AR_data_out, 'hE09);
        step(1'b1, 1'b0, 1'b1, 12'h555);
        chk("inc2", if_a.AR_data_out, 'hE0A);
        step(1'b1, 1'b0, 1'b1, 12'h555);
        chk("inc3", if_a.AR_data_out, 'hE0B);
        step(1'b1, 1'b1, 1'b1, 12'h123);
        chk("priority", if_a.AR_data_out, 'h123);
        step(1'b1, 1'b0, 1'b0, 12'hFFF);
        chk("hold1", if_a.AR_data_out, 'h123);
        step(1'b1, 1'b0, 1'b0, 12'h000);
        chk("hold2", if_a.AR_data_out, 'h123);
        step(1'b1, 1'b1, 1'b0, 12'hFFF);
        step(1'b1, 1'b0, 1'b1, 12'h000);
        chk("wrap", if_a.AR_data_out, 'h000);
        step(1'b0, 1'b0, 1'b1, 12'h777);
        chk("midreset_a", if_a.AR_data_out, 'h000);
        chk("midreset_b", if_b.AR_data_out, 'h100);
        step(1'b0, 1'b1, 1'b1, 12'h777);
        chk("heldreset_b", if_b.AR_data_out, 'h100);
        step(1'b1, 1'b0, 1'b1, 12'h000);
        chk("vec_inc_a", if_a.AR_data_out, 'h001);
        chk("vec_inc_b", if_b.AR_data_out, 'h101);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(15) != 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
                 $urandom_range(3) == 0 ? 12'hFFE + 12'($urandom_range(1)) : 12'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 12-bit (parameterisable) program counter register for the processor datapath.
- Loads a jump/branch target from the shared data bus, or increments by one to step to the next instruction.
- Drives its current value continuously to the address register (AR).
- Single clock domain; all state changes on the rising clock edge.

Parameters:
- reg_width, 12, width in bits of the PC register, bus input and AR output.
- current_PC_value, 0 (12'b000000000000), value loaded into the PC on reset (reset vector).

Ports:
- clk  input  1  system clock; all updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- write_en  input  1  load enable; when high, PC takes bus_data_in.
- increment  input  1  increment enable (PC_Inc); when high and write_en low, PC advances by 1.
- bus_data_in  input  reg_width  data from the shared bus (load value).
- AR_data_out  output  reg_width  current PC value, driven to the address register.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are named clk and reset.
- State: one reg_width-bit register, pc. AR_data_out is driven directly from pc, with no combinational path from any input.
- The following is evaluated at each rising edge of clk, in priority order:
  1. reset == 0: pc <= current_PC_value. This overrides write_en and increment.
  2. write_en == 1: pc <= bus_data_in.
  3. increment == 1: pc <= pc + 1, modulo 2^reg_width.
  4. Otherwise: pc holds its value.
- Latency: a load or increment is visible on AR_data_out one clock edge after it is sampled. No multi-cycle operations and no handshake.
- Simultaneous write_en and increment: the write wins. pc becomes bus_data_in, not bus_data_in+1.
- Wrap-around: increment from all-ones (12'hFFF) gives 12'h000. No carry or overflow flag.
- Reset mid-operation: reset asserted on any edge discards that cycle's pending load or increment. pc equals current_PC_value after that edge.
- Reset held low for several cycles: pc stays at current_PC_value.
- Before the first reset edge, the pc value is unspecified. Users must apply reset before relying on AR_data_out.
- X or Z inputs on write_en or increment when reset is high are not supported. The bench drives known values after reset.
- The design is fully synthesizable: no initial blocks, and no latches.

Test Plan:
- Reset: drive reset=0 for 1 edge, write_en=1, bus_data_in=12'hABC -> AR_data_out=12'h000 after the edge; the load is ignored.
- Bus load: reset=1, write_en=1, increment=0, bus_data_in=12'b111000001000 (12'hE08) -> AR_data_out=12'hE08 after the next edge.
- Increment: after the load above, write_en=0, increment=1 for 3 edges -> AR_data_out=12'hE09, 12'hE0A, 12'hE0B on successive edges.
- Priority and hold:
  - write_en=1, increment=1, bus_data_in=12'h123 -> 12'h123.
  - Then write_en=0, increment=0 for 2 edges -> stays 12'h123.
- Wrap: load 12'hFFF, then increment=1 -> 12'h000.
- Non-zero reset vector: instantiate with current_PC_value=12'h100 and reg_width=12, then pulse reset low -> 12'h100. Increment once -> 12'h101.
